// File: rtl/measure_stats.sv
// Per-flow latency and throughput statistics for probe frames on a 64-bit beat stream.
// Live counters are copied to snapshots and cleared on each sec_oneshot; reads see snapshots only.
//
// state | meaning
// IDLE  | waiting for a valid SOP
// PARSE | counting beats up to the timestamp beat
// TAIL  | skipping remaining beats until EOP
module measure_stats #(
    parameter int          N_FLOWS    = 4,
    parameter logic [39:0] MAGIC_CODE = 40'h4d41_4755_4b,
    parameter int          MAGIC_BEAT = 5,
    localparam int         FLOW_W     = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [63:0]       rx_data,
    input  logic [7:0]        rx_keep,
    input  logic              rx_valid,
    input  logic              rx_sop,
    input  logic              rx_eop,
    input  logic [31:0]       global_counter,
    input  logic              sec_oneshot,
    input  logic [FLOW_W-1:0] rd_flow,
    input  logic [2:0]        rd_sel,
    output logic [31:0]       rd_data,
    output logic [31:0]       rx_pps,
    output logic [31:0]       rx_throughput,
    output logic [31:0]       unknown_flow_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_PARSE, S_TAIL} state_t;

    localparam logic [5:0] SIG_BEAT = 6'(MAGIC_BEAT);
    localparam logic [5:0] LAT_BEAT = 6'(MAGIC_BEAT + 1);

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    function automatic logic [47:0] sat_add48(input logic [47:0] a, input logic [47:0] b);
        logic [48:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[48] ? 48'hFFFF_FFFF_FFFF : s[47:0];
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  beat_q, beat_d;
    logic [15:0] len_q, len_d;
    logic        match_q, match_d;
    logic        lat_vld_q, lat_vld_d;
    logic [7:0]  flow_q, flow_d;
    logic [31:0] lat_q, lat_d;
    logic        commit_q, commit_d;

    logic [31:0] agg_frames_q, agg_frames_d;
    logic [31:0] agg_bytes_q, agg_bytes_d;
    logic [31:0] pps_q, pps_d;
    logic [31:0] tput_q, tput_d;
    logic [31:0] unknown_q, unknown_d;
    logic [31:0] rd_data_q, rd_data_d;

    logic [31:0] fr_q [N_FLOWS];
    logic [31:0] fr_d [N_FLOWS];
    logic [31:0] by_q [N_FLOWS];
    logic [31:0] by_d [N_FLOWS];
    logic [31:0] last_q [N_FLOWS];
    logic [31:0] last_d [N_FLOWS];
    logic [31:0] min_q [N_FLOWS];
    logic [31:0] min_d [N_FLOWS];
    logic [31:0] max_q [N_FLOWS];
    logic [31:0] max_d [N_FLOWS];
    logic [47:0] sum_q [N_FLOWS];
    logic [47:0] sum_d [N_FLOWS];

    logic [31:0] sfr_q [N_FLOWS];
    logic [31:0] sfr_d [N_FLOWS];
    logic [31:0] sby_q [N_FLOWS];
    logic [31:0] sby_d [N_FLOWS];
    logic [31:0] slast_q [N_FLOWS];
    logic [31:0] slast_d [N_FLOWS];
    logic [31:0] smin_q [N_FLOWS];
    logic [31:0] smin_d [N_FLOWS];
    logic [31:0] smax_q [N_FLOWS];
    logic [31:0] smax_d [N_FLOWS];
    logic [47:0] ssum_q [N_FLOWS];
    logic [47:0] ssum_d [N_FLOWS];

    logic [3:0] keep_cnt;
    logic       flow_known;
    logic       unused_data;

    assign unused_data = ^rx_data[15:0];
    assign flow_known  = ({24'd0, flow_q} < 32'(N_FLOWS));

    always_comb begin
        keep_cnt = 4'd0;
        for (int i = 0; i < 8; i++) keep_cnt = keep_cnt + {3'd0, rx_keep[i]};
    end

    // Frame parser: a valid SOP restarts parsing from any state, abandoning the old frame.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        len_d     = len_q;
        match_d   = match_q;
        lat_vld_d = lat_vld_q;
        flow_d    = flow_q;
        lat_d     = lat_q;
        commit_d  = 1'b0;
        if (rx_valid && rx_sop) begin
            match_d   = 1'b0;
            lat_vld_d = 1'b0;
            flow_d    = 8'd0;
            lat_d     = 32'd0;
            beat_d    = 6'd1;
            if (rx_eop) begin
                len_d    = {12'd0, keep_cnt};
                commit_d = 1'b1;
                state_d  = S_IDLE;
            end else begin
                len_d   = 16'd8;
                state_d = S_PARSE;
            end
        end else if (rx_valid && state_q != S_IDLE) begin
            if (state_q == S_PARSE && beat_q == SIG_BEAT) begin
                match_d = (rx_data[63:24] == MAGIC_CODE);
                flow_d  = rx_data[23:16];
            end
            if (state_q == S_PARSE && beat_q == LAT_BEAT && match_q) begin
                lat_d     = global_counter - rx_data[63:32];
                lat_vld_d = 1'b1;
            end
            if (rx_eop) begin
                len_d    = sat_add16(len_q, {12'd0, keep_cnt});
                commit_d = 1'b1;
                state_d  = S_IDLE;
            end else begin
                len_d = sat_add16(len_q, 16'd8);
                if (state_q == S_PARSE) begin
                    if (beat_q == LAT_BEAT) state_d = S_TAIL;
                    else                    beat_d  = beat_q + 6'd1;
                end
            end
        end
    end

    // The tick clears live state first so a coincident commit lands in the new interval.
    always_comb begin
        agg_frames_d = agg_frames_q;
        agg_bytes_d  = agg_bytes_q;
        pps_d        = pps_q;
        tput_d       = tput_q;
        unknown_d    = unknown_q;
        fr_d = fr_q;   by_d = by_q;   last_d = last_q;
        min_d = min_q; max_d = max_q; sum_d = sum_q;
        sfr_d = sfr_q;   sby_d = sby_q;   slast_d = slast_q;
        smin_d = smin_q; smax_d = smax_q; ssum_d = ssum_q;
        if (sec_oneshot) begin
            pps_d        = agg_frames_q;
            tput_d       = agg_bytes_q;
            agg_frames_d = 32'd0;
            agg_bytes_d  = 32'd0;
            sfr_d = fr_q;   sby_d = by_q;   slast_d = last_q;
            smin_d = min_q; smax_d = max_q; ssum_d = sum_q;
            for (int f = 0; f < N_FLOWS; f++) begin
                fr_d[f]   = 32'd0;
                by_d[f]   = 32'd0;
                last_d[f] = 32'd0;
                min_d[f]  = 32'hFFFF_FFFF;
                max_d[f]  = 32'd0;
                sum_d[f]  = 48'd0;
            end
        end
        if (commit_q) begin
            agg_frames_d = sat_add32(agg_frames_d, 32'd1);
            agg_bytes_d  = sat_add32(agg_bytes_d, {16'd0, len_q});
            if (match_q && !flow_known) unknown_d = sat_add32(unknown_q, 32'd1);
            if (match_q && lat_vld_q && flow_known) begin
                for (int f = 0; f < N_FLOWS; f++) begin
                    if (flow_q == 8'(f)) begin
                        fr_d[f]   = sat_add32(fr_d[f], 32'd1);
                        by_d[f]   = sat_add32(by_d[f], {16'd0, len_q});
                        last_d[f] = lat_q;
                        if (lat_q < min_d[f]) min_d[f] = lat_q;
                        if (lat_q > max_d[f]) max_d[f] = lat_q;
                        sum_d[f]  = sat_add48(sum_d[f], {16'd0, lat_q});
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data_d = 32'd0;
        if (rd_sel == 3'd7) begin
            rd_data_d = unknown_q;
        end else begin
            for (int f = 0; f < N_FLOWS; f++) begin
                if (rd_flow == FLOW_W'(f)) begin
                    case (rd_sel)
                        3'd0:    rd_data_d = sfr_q[f];
                        3'd1:    rd_data_d = sby_q[f];
                        3'd2:    rd_data_d = slast_q[f];
                        3'd3:    rd_data_d = smin_q[f];
                        3'd4:    rd_data_d = smax_q[f];
                        3'd5:    rd_data_d = ssum_q[f][31:0];
                        default: rd_data_d = {16'd0, ssum_q[f][47:32]};
                    endcase
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            beat_q       <= 6'd0;
            len_q        <= 16'd0;
            match_q      <= 1'b0;
            lat_vld_q    <= 1'b0;
            flow_q       <= 8'd0;
            lat_q        <= 32'd0;
            commit_q     <= 1'b0;
            agg_frames_q <= 32'd0;
            agg_bytes_q  <= 32'd0;
            pps_q        <= 32'd0;
            tput_q       <= 32'd0;
            unknown_q    <= 32'd0;
            rd_data_q    <= 32'd0;
            for (int f = 0; f < N_FLOWS; f++) begin
                fr_q[f]    <= 32'd0;
                by_q[f]    <= 32'd0;
                last_q[f]  <= 32'd0;
                min_q[f]   <= 32'hFFFF_FFFF;
                max_q[f]   <= 32'd0;
                sum_q[f]   <= 48'd0;
                sfr_q[f]   <= 32'd0;
                sby_q[f]   <= 32'd0;
                slast_q[f] <= 32'd0;
                smin_q[f]  <= 32'hFFFF_FFFF;
                smax_q[f]  <= 32'd0;
                ssum_q[f]  <= 48'd0;
            end
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            len_q        <= len_d;
            match_q      <= match_d;
            lat_vld_q    <= lat_vld_d;
            flow_q       <= flow_d;
            lat_q        <= lat_d;
            commit_q     <= commit_d;
            agg_frames_q <= agg_frames_d;
            agg_bytes_q  <= agg_bytes_d;
            pps_q        <= pps_d;
            tput_q       <= tput_d;
            unknown_q    <= unknown_d;
            rd_data_q    <= rd_data_d;
            for (int f = 0; f < N_FLOWS; f++) begin
                fr_q[f]    <= fr_d[f];
                by_q[f]    <= by_d[f];
                last_q[f]  <= last_d[f];
                min_q[f]   <= min_d[f];
                max_q[f]   <= max_d[f];
                sum_q[f]   <= sum_d[f];
                sfr_q[f]   <= sfr_d[f];
                sby_q[f]   <= sby_d[f];
                slast_q[f] <= slast_d[f];
                smin_q[f]  <= smin_d[f];
                smax_q[f]  <= smax_d[f];
                ssum_q[f]  <= ssum_d[f];
            end
        end
    end

    assign rd_data          = rd_data_q;
    assign rx_pps           = pps_q;
    assign rx_throughput    = tput_q;
    assign unknown_flow_cnt = unknown_q;

endmodule

// File: tb/tb_measure_stats.sv
// Bench for measure_stats: directed scenarios then random frames, checked against
// an interval-level statistics model kept in plain arrays.
module tb_measure_stats;

    localparam int          NF    = 4;
    localparam int          MB    = 5;
    localparam logic [39:0] MAGIC = 40'h4d41_4755_4b;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [63:0] rx_data;
    logic [7:0]  rx_keep;
    logic        rx_valid, rx_sop, rx_eop;
    logic [31:0] global_counter;
    logic        sec_oneshot;
    logic [1:0]  rd_flow;
    logic [2:0]  rd_sel;
    logic [31:0] rd_data, rx_pps, rx_throughput, unknown_flow_cnt;

    measure_stats #(.N_FLOWS(NF), .MAGIC_CODE(MAGIC), .MAGIC_BEAT(MB)) dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .rx_data          (rx_data),
        .rx_keep          (rx_keep),
        .rx_valid         (rx_valid),
        .rx_sop           (rx_sop),
        .rx_eop           (rx_eop),
        .global_counter   (global_counter),
        .sec_oneshot      (sec_oneshot),
        .rd_flow          (rd_flow),
        .rd_sel           (rd_sel),
        .rd_data          (rd_data),
        .rx_pps           (rx_pps),
        .rx_throughput    (rx_throughput),
        .unknown_flow_cnt (unknown_flow_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    // reference model: live interval totals, snapshots, and the never-cleared unknown count
    logic [31:0] m_agg_fr, m_agg_by, m_pps, m_tput, m_unk;
    logic [31:0] m_fr [NF];
    logic [31:0] m_by [NF];
    logic [31:0] m_last [NF];
    logic [31:0] m_min [NF];
    logic [31:0] m_max [NF];
    logic [47:0] m_sum [NF];
    logic [31:0] s_fr [NF];
    logic [31:0] s_by [NF];
    logic [31:0] s_last [NF];
    logic [31:0] s_min [NF];
    logic [31:0] s_max [NF];
    logic [47:0] s_sum [NF];

    task automatic model_clear_live();
        m_agg_fr = 0;
        m_agg_by = 0;
        for (int f = 0; f < NF; f++) begin
            m_fr[f] = 0; m_by[f] = 0; m_last[f] = 0;
            m_min[f] = 32'hFFFF_FFFF; m_max[f] = 0; m_sum[f] = 0;
        end
    endtask

    task automatic model_reset();
        model_clear_live();
        m_pps = 0; m_tput = 0; m_unk = 0;
        for (int f = 0; f < NF; f++) begin
            s_fr[f] = 0; s_by[f] = 0; s_last[f] = 0;
            s_min[f] = 32'hFFFF_FFFF; s_max[f] = 0; s_sum[f] = 0;
        end
    endtask

    task automatic model_tick();
        m_pps  = m_agg_fr;
        m_tput = m_agg_by;
        s_fr = m_fr; s_by = m_by; s_last = m_last;
        s_min = m_min; s_max = m_max; s_sum = m_sum;
        model_clear_live();
    endtask

    // probe = frame carries signature and timestamp beats
    task automatic model_frame(input int nbytes, input bit probe, input int flow, input logic [31:0] lat);
        m_agg_fr = m_agg_fr + 1;
        m_agg_by = m_agg_by + 32'(nbytes);
        if (probe) begin
            if (flow < NF) begin
                m_fr[flow]   = m_fr[flow] + 1;
                m_by[flow]   = m_by[flow] + 32'(nbytes);
                m_last[flow] = lat;
                if (lat < m_min[flow]) m_min[flow] = lat;
                if (lat > m_max[flow]) m_max[flow] = lat;
                m_sum[flow]  = m_sum[flow] + {16'd0, lat};
            end else begin
                m_unk = m_unk + 1;
            end
        end
    endtask

    function automatic logic [31:0] model_sel(input int f, input int sel);
        logic [47:0] s;
        s = s_sum[f];
        case (sel)
            0: return s_fr[f];
            1: return s_by[f];
            2: return s_last[f];
            3: return s_min[f];
            4: return s_max[f];
            5: return s[31:0];
            6: return {16'd0, s[47:32]};
            default: return m_unk;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] keep_mask(input int nb);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < nb; i++) m[7-i] = 1'b1;
        return m;
    endfunction

    task automatic idle_cycle(input bit tick);
        @(negedge sys_clk);
        rx_valid    = 1'b0;
        rx_sop      = 1'($urandom_range(0, 1));
        rx_eop      = 1'($urandom_range(0, 1));
        rx_data     = {$urandom, $urandom};
        sec_oneshot = tick;
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic s, input logic e,
                              input logic [31:0] gc);
        @(negedge sys_clk);
        rx_data        = d;
        rx_keep        = k;
        rx_sop         = s;
        rx_eop         = e;
        rx_valid       = 1'b1;
        global_counter = gc;
        sec_oneshot    = 1'b0;
    endtask

    // stop_beat >= 0 sends only beats [0, stop_beat) and leaves the frame open
    task automatic send_frame(input int nbytes, input bit probe, input logic [7:0] flow,
                              input logic [31:0] ts, input logic [31:0] gc_at,
                              input int stop_beat, input bit gaps);
        int nbeats, rem;
        logic [63:0] d;
        logic [31:0] gc;
        logic        last;
        nbeats = (nbytes + 7) / 8;
        rem    = nbytes - 8 * (nbeats - 1);
        for (int b = 0; b < nbeats; b++) begin
            if (stop_beat >= 0 && b >= stop_beat) break;
            d  = {$urandom, $urandom};
            gc = $urandom;
            if (b == MB) begin
                if (probe) begin
                    d[63:24] = MAGIC;
                    d[23:16] = flow;
                end else if (d[63:24] == MAGIC) begin
                    d[63] = ~d[63];
                end
            end
            if (b == MB + 1 && probe) begin
                d[63:32] = ts;
                gc       = gc_at;
            end
            last = (b == nbeats - 1) && (stop_beat < 0);
            if (gaps && b > 0 && $urandom_range(0, 3) == 0) idle_cycle(1'b0);
            drive_beat(d, last ? keep_mask(rem) : 8'hFF, b == 0, last, gc);
        end
    endtask

    task automatic frame(input int nbytes, input bit probe, input int flow, input logic [31:0] ts,
                         input logic [31:0] gc_at, input bit gaps, input bit tick);
        send_frame(nbytes, probe, 8'(flow), ts, gc_at, -1, gaps);
        idle_cycle(tick);
        if (tick) begin
            idle_cycle(1'b0);
            model_tick();
        end
        model_frame(nbytes, probe, flow, gc_at - ts);
    endtask

    task automatic do_tick();
        idle_cycle(1'b1);
        idle_cycle(1'b0);
        model_tick();
    endtask

    task automatic read_expect(input string tag, input int f, input int sel, input logic [31:0] exp);
        @(negedge sys_clk);
        rx_valid    = 1'b0;
        sec_oneshot = 1'b0;
        rd_flow     = 2'(f);
        rd_sel      = 3'(sel);
        @(negedge sys_clk);
        check(tag, rd_data, exp);
    endtask

    task automatic check_snap(input string tag);
        check({tag, " pps"}, rx_pps, m_pps);
        check({tag, " tput"}, rx_throughput, m_tput);
        check({tag, " unk"}, unknown_flow_cnt, m_unk);
        for (int f = 0; f < NF; f++) begin
            for (int s = 0; s < 8; s++) begin
                if (s == 2 && s_fr[f] == 0) continue;
                read_expect($sformatf("%s f%0d sel%0d", tag, f, s), f, s, model_sel(f, s));
            end
        end
    endtask

    initial begin
        logic [31:0] old_val;
        sys_rst_n = 1'b0; rx_data = '0; rx_keep = 8'hFF; rx_valid = 1'b0; rx_sop = 1'b0;
        rx_eop = 1'b0; global_counter = '0; sec_oneshot = 1'b0; rd_flow = '0; rd_sel = '0;
        model_reset();
        repeat (3) @(negedge sys_clk);
        check("rst rd_data", rd_data, 32'd0);
        check("rst pps", rx_pps, 32'd0);
        check("rst tput", rx_throughput, 32'd0);
        check("rst unk", unknown_flow_cnt, 32'd0);
        sys_rst_n = 1'b1;
        check_snap("reset");

        // single 64-byte probe, flow 2, latency 350-100
        frame(64, 1'b1, 2, 32'd100, 32'd350, 1'b0, 1'b0);
        do_tick();
        read_expect("p1 frames", 2, 0, 32'd1);
        read_expect("p1 bytes", 2, 1, 32'd64);
        read_expect("p1 last", 2, 2, 32'd250);
        read_expect("p1 min", 2, 3, 32'd250);
        read_expect("p1 max", 2, 4, 32'd250);
        check_snap("probe1");

        // timestamp wrap
        frame(72, 1'b1, 1, 32'hFFFF_FFF0, 32'h10, 1'b1, 1'b0);
        do_tick();
        read_expect("wrap last", 1, 2, 32'h20);
        check_snap("wrap");

        // unknown flow id
        frame(64, 1'b1, 9, 32'd5, 32'd9, 1'b0, 1'b0);
        do_tick();
        check("unk cnt", unknown_flow_cnt, 32'd1);
        check("unk pps", rx_pps, 32'd1);
        check_snap("unknown");

        // SOP at beat 3 abandons the open probe
        send_frame(80, 1'b1, 8'd0, 32'd1, 32'd2, 3, 1'b0);
        frame(60, 1'b0, 0, 32'd0, 32'd0, 1'b0, 1'b0);
        do_tick();
        check("abandon pps", rx_pps, 32'd1);
        check("abandon tput", rx_throughput, 32'd60);
        check_snap("abandon");

        // commit coincident with the tick
        frame(64, 1'b1, 0, 32'd10, 32'd40, 1'b0, 1'b1);
        check("coin pps0", rx_pps, 32'd0);
        check_snap("coin0");
        do_tick();
        check("coin pps1", rx_pps, 32'd1);
        check_snap("coin1");

        // read in the same cycle as a tick returns the old snapshot
        frame(64, 1'b1, 3, 32'd1, 32'd12, 1'b0, 1'b0);
        old_val = model_sel(3, 0);
        @(negedge sys_clk);
        rd_flow = 2'd3; rd_sel = 3'd0; sec_oneshot = 1'b1; rx_valid = 1'b0;
        @(negedge sys_clk);
        sec_oneshot = 1'b0;
        check("rd during tick", rd_data, old_val);
        model_tick();
        check_snap("post tick read");

        // reset at beat 4 of a probe; the rest of that frame must be ignored
        send_frame(80, 1'b1, 8'd3, 32'd0, 32'd99, 4, 1'b0);
        @(negedge sys_clk);
        rx_valid  = 1'b0;
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst pps", rx_pps, 32'd0);
        check("midrst unk", unknown_flow_cnt, 32'd0);
        check("midrst rd", rd_data, 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int b = 4; b < 10; b++)
            drive_beat({$urandom, $urandom}, 8'hFF, 1'b0, b == 9, $urandom);
        idle_cycle(1'b0);
        frame(64, 1'b1, 3, 32'd1000, 32'd1007, 1'b0, 1'b0);
        do_tick();
        read_expect("rst min", 3, 3, 32'd7);
        read_expect("rst max", 3, 4, 32'd7);
        read_expect("rst frames", 3, 0, 32'd1);
        check_snap("after rst");

        // random traffic over several intervals
        for (int iv = 0; iv < 5; iv++) begin
            int nfr;
            nfr = $urandom_range(3, 8);
            for (int i = 0; i < nfr; i++) begin
                bit pr;
                int nb;
                bit tk;
                pr = 1'($urandom_range(0, 1));
                nb = pr ? $urandom_range(56, 200) : $urandom_range(1, 200);
                tk = (i == nfr - 1) && ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 3) == 0) begin
                    drive_beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'($urandom_range(0, 1)), $urandom);
                    idle_cycle(1'b0);
                end
                frame(nb, pr, $urandom_range(0, 5), $urandom, $urandom, 1'b1, tk);
            end
            do_tick();
            check_snap($sformatf("rand%0d", iv));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
